// File: rtl/life_pkg.sv
// life_pkg: Conway life rule constants and the per-cell next-state rule.
package life_pkg;
   localparam int NCNT_W = 4;
   localparam logic [NCNT_W-1:0] BIRTH_N  = 4'd3;
   localparam logic [NCNT_W-1:0] SURV_MIN = 4'd2;
   localparam logic [NCNT_W-1:0] SURV_MAX = 4'd3;
   function automatic logic next_state(input logic alive, input logic [NCNT_W-1:0] cnt);
      return alive ? (cnt >= SURV_MIN && cnt <= SURV_MAX) : (cnt == BIRTH_N);
   endfunction
endpackage

// File: rtl/life_cell.sv
// life_cell: one life cell; in-cell priority scan > write > enb.
module life_cell
   import life_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] nbr,
   input  logic       write,
   input  logic       val,
   input  logic       enb,
   input  logic       scan,
   input  logic       scan_val,
   output logic       alive,
   output logic       nxt
);
   logic [NCNT_W-1:0] cnt;
   always_comb begin
      cnt = '0;
      for (int k = 0; k < 8; k++) cnt += NCNT_W'(nbr[k]);
   end
   assign nxt = next_state(alive, cnt);
   always_ff @(posedge clk)
      if (reset) alive <= 1'b0;
      else if (scan) alive <= scan_val;
      else if (write) alive <= val;
      else if (enb) alive <= nxt;
endmodule

// File: rtl/life_col_n.sv
// life_col_n: parametrised column of life cells with wrap, scan/shift, popcount and generation tracking.
module life_col_n
   import life_pkg::*;
#(
   parameter int ROWS  = 8,
   parameter int ROW_W = $clog2(ROWS),
   parameter int POP_W = $clog2(ROWS + 1),
   parameter int GEN_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [ROWS-1:0]  w_col,
   input  logic [ROWS-1:0]  e_col,
   input  logic             n,
   input  logic             ne,
   input  logic             nw,
   input  logic             s,
   input  logic             se,
   input  logic             sw,
   input  logic             wrap,
   input  logic             write_enb,
   input  logic             val,
   input  logic [ROW_W-1:0] row,
   input  logic             scan,
   input  logic [ROWS-1:0]  scan_val,
   input  logic             shift_en,
   input  logic             shift_in,
   output logic             shift_out,
   input  logic             enable,
   output logic [ROWS-1:0]  alive_col,
   output logic [POP_W-1:0] pop_count,
   output logic [GEN_W-1:0] gen_count,
   output logic             changed
);
   logic [ROWS-1:0]  next_col;
   logic [POP_W-1:0] pop;
   logic             step;
   assign step      = enable & ~scan & ~shift_en & ~write_enb;
   assign shift_out = alive_col[ROWS-1];
   for (genvar i = 0; i < ROWS; i++) begin : g_cell
      localparam int UP = (i + ROWS - 1) % ROWS;
      localparam int DN = (i + 1) % ROWS;
      logic [2:0] up3, dn3;
      logic       sv;
      // Edge rows take outer neighbours from the ports unless the column is a torus.
      assign up3 = (i == 0 && !wrap) ? {nw, n, ne} : {w_col[UP], alive_col[UP], e_col[UP]};
      assign dn3 = (i == ROWS - 1 && !wrap) ? {sw, s, se} : {w_col[DN], alive_col[DN], e_col[DN]};
      assign sv  = scan ? scan_val[i] : (i == 0 ? shift_in : alive_col[UP]);
      life_cell u_cell (
         .clk,
         .reset,
         .nbr      ({up3, w_col[i], e_col[i], dn3}),
         .write    (write_enb && row == ROW_W'(i)),
         .val,
         .enb      (step),
         .scan     (scan | shift_en),
         .scan_val (sv),
         .alive    (alive_col[i]),
         .nxt      (next_col[i])
      );
   end
   always_comb begin
      pop = '0;
      for (int k = 0; k < ROWS; k++) pop += POP_W'(alive_col[k]);
   end
   always_ff @(posedge clk)
      if (reset) begin
         gen_count <= '0;
         changed   <= 1'b0;
         pop_count <= '0;
      end else begin
         pop_count <= pop;
         if (scan) begin
            gen_count <= '0;
            changed   <= 1'b0;
         end else if (step) begin
            gen_count <= gen_count + 1'b1;
            changed   <= next_col != alive_col;
         end
      end
endmodule

// File: tb/tb_life_col_n.sv
// tb_life_col_n: table vectors, corner sequences and a random run against a neighbour-counting model.
module tb_life_col_n;
   logic clk = 1'b0;
   logic reset, wrap, write_enb, val, scan, shift_en, shift_in, enable;
   logic n, ne, nw, s, se, sw;
   logic [7:0] w_col, e_col, scan_val, alive_col;
   logic [2:0] row;
   logic shift_out, changed;
   logic [3:0] pop_count;
   logic [15:0] gen_count;
   logic [9:0] sv10, a10;
   logic [3:0] row10, pop10;
   logic we10, val10, sc10, so10, chg10;
   logic [15:0] gen10;
   int ncmp = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   life_col_n #(.ROWS(8)) dut (
      .clk, .reset, .w_col, .e_col, .n, .ne, .nw, .s, .se, .sw, .wrap,
      .write_enb, .val, .row, .scan, .scan_val, .shift_en, .shift_in,
      .shift_out, .enable, .alive_col, .pop_count, .gen_count, .changed
   );

   life_col_n #(.ROWS(10)) dut10 (
      .clk, .reset, .w_col(10'd0), .e_col(10'd0), .n(1'b0), .ne(1'b0), .nw(1'b0),
      .s(1'b0), .se(1'b0), .sw(1'b0), .wrap(1'b0), .write_enb(we10), .val(val10),
      .row(row10), .scan(sc10), .scan_val(sv10), .shift_en(1'b0), .shift_in(1'b0),
      .shift_out(so10), .enable(1'b0), .alive_col(a10), .pop_count(pop10),
      .gen_count(gen10), .changed(chg10)
   );

   typedef struct {
      logic [7:0] sv, w, e;
      logic       wr;
      logic [2:0] top, bot;
      logic [7:0] exp;
      logic       chg;
   } vec_t;
   vec_t tbl[9];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Cell state at (row rr, column offset dc) as seen from inside the column.
   function automatic int cell_at(input logic [7:0] a, w, e, input logic wr,
                                  input logic [2:0] top, bot, input int rr, input int dc);
      if (rr < 0 && !wr) return int'(top[1-dc]);
      if (rr > 7 && !wr) return int'(bot[1-dc]);
      rr = (rr + 8) % 8;
      return dc < 0 ? int'(w[rr]) : dc > 0 ? int'(e[rr]) : int'(a[rr]);
   endfunction

   function automatic logic [7:0] ref_step(input logic [7:0] a, w, e, input logic wr,
                                           input logic [2:0] top, bot);
      logic [7:0] r;
      int c;
      for (int i = 0; i < 8; i++) begin
         c = 0;
         for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
               if (dr != 0 || dc != 0) c += cell_at(a, w, e, wr, top, bot, i + dr, dc);
         r[i] = a[i] ? (c == 2 || c == 3) : (c == 3);
      end
      return r;
   endfunction

   task automatic idle;
      reset = 0; wrap = 0; write_enb = 0; val = 0; scan = 0; shift_en = 0;
      shift_in = 0; enable = 0; n = 0; ne = 0; nw = 0; s = 0; se = 0; sw = 0;
      w_col = 0; e_col = 0; scan_val = 0; row = 0;
   endtask

   initial begin
      logic [7:0] m_a, prev, nx;
      logic [15:0] m_gen;
      logic m_chg;
      logic [3:0] m_pop;
      tbl[0] = '{8'h10, 8'h10, 8'h10, 1'b0, 3'b000, 3'b000, 8'h38, 1'b1};
      tbl[1] = '{8'h83, 8'h00, 8'h00, 1'b1, 3'b000, 3'b000, 8'h01, 1'b1};
      tbl[2] = '{8'h83, 8'h00, 8'h00, 1'b0, 3'b000, 3'b000, 8'h00, 1'b1};
      tbl[3] = '{8'h1C, 8'h00, 8'h00, 1'b0, 3'b000, 3'b000, 8'h08, 1'b1};
      tbl[4] = '{8'h18, 8'h18, 8'h00, 1'b0, 3'b000, 3'b000, 8'h18, 1'b0};
      tbl[5] = '{8'h00, 8'h00, 8'h00, 1'b0, 3'b000, 3'b000, 8'h00, 1'b0};
      tbl[6] = '{8'h00, 8'h00, 8'h00, 1'b0, 3'b111, 3'b000, 8'h01, 1'b1};
      tbl[7] = '{8'h00, 8'h00, 8'h00, 1'b1, 3'b111, 3'b111, 8'h00, 1'b0};
      tbl[8] = '{8'h00, 8'h00, 8'h00, 1'b0, 3'b000, 3'b111, 8'h80, 1'b1};
      idle();
      sv10 = 0; row10 = 0; we10 = 0; val10 = 0; sc10 = 0;
      reset = 1;
      tick(); tick();
      chk("reset_alive", 32'(alive_col), 32'h00);
      chk("reset_pop", 32'(pop_count), 0);
      chk("reset_gen", 32'(gen_count), 0);
      chk("reset_changed", 32'(changed), 0);
      reset = 0;

      for (int v = 0; v < 9; v++) begin
         idle();
         scan = 1; scan_val = tbl[v].sv;
         tick();
         idle();
         enable = 1; w_col = tbl[v].w; e_col = tbl[v].e; wrap = tbl[v].wr;
         {nw, n, ne} = tbl[v].top; {sw, s, se} = tbl[v].bot;
         tick();
         enable = 0;
         chk($sformatf("tbl%0d_alive", v), 32'(alive_col), 32'(tbl[v].exp));
         chk($sformatf("tbl%0d_gen", v), 32'(gen_count), 1);
         chk($sformatf("tbl%0d_changed", v), 32'(changed), 32'(tbl[v].chg));
         tick();
         chk($sformatf("tbl%0d_pop", v), 32'(pop_count), 32'($countones(tbl[v].exp)));
      end

      idle();
      scan = 1; tick(); scan = 0;
      shift_en = 1;
      shift_in = 1; tick();
      shift_in = 0; tick();
      shift_in = 1; tick();
      chk("shift3_alive", 32'(alive_col), 32'h05);
      chk("shift3_out", 32'(shift_out), 0);
      shift_in = 0;
      repeat (5) tick();
      chk("shift8_out", 32'(shift_out), 1);
      chk("shift8_alive", 32'(alive_col), 32'hA0);
      chk("shift_gen_hold", 32'(gen_count), 0);
      shift_en = 0;

      scan = 1; scan_val = 8'hA5; write_enb = 1; row = 0; val = 0; enable = 1;
      tick();
      chk("scan_prio_alive", 32'(alive_col), 32'hA5);
      chk("scan_prio_gen", 32'(gen_count), 0);
      scan = 0; row = 1; val = 1;
      tick();
      chk("write_prio_alive", 32'(alive_col), 32'hA7);
      chk("write_prio_gen", 32'(gen_count), 0);
      idle();

      sc10 = 1; we10 = 1; row10 = 9; val10 = 1; tick();
      chk("r10_scan_over_write", 32'(a10), 0);
      sc10 = 0; row10 = 12; tick();
      chk("r10_oob_write", 32'(a10), 0);
      row10 = 9; tick();
      chk("r10_row9_write", 32'(a10), 32'h200);
      we10 = 0;

      scan = 1; scan_val = 0; tick(); scan = 0;
      enable = 1; repeat (3) tick(); enable = 0;
      chk("empty_alive", 32'(alive_col), 0);
      chk("empty_changed", 32'(changed), 0);
      chk("empty_gen", 32'(gen_count), 3);
      scan = 1; scan_val = 8'h1C; tick(); scan = 0;
      enable = 1; tick();
      chk("midrun_gen", 32'(gen_count), 1);
      reset = 1; tick();
      chk("midrst_alive", 32'(alive_col), 0);
      chk("midrst_gen", 32'(gen_count), 0);
      chk("midrst_changed", 32'(changed), 0);
      chk("midrst_pop", 32'(pop_count), 0);
      reset = 0; enable = 0;

      m_a = 0; m_gen = 0; m_chg = 0; m_pop = 0;
      idle(); reset = 1; tick();
      for (int it = 0; it < 600; it++) begin
         reset = ($urandom_range(0, 99) < 2);
         scan = ($urandom_range(0, 99) < 6);
         shift_en = ($urandom_range(0, 99) < 12);
         write_enb = ($urandom_range(0, 99) < 15);
         enable = ($urandom_range(0, 99) < 60);
         scan_val = 8'($urandom); w_col = 8'($urandom); e_col = 8'($urandom);
         wrap = 1'($urandom); shift_in = 1'($urandom); val = 1'($urandom);
         row = 3'($urandom); {n, ne, nw, s, se, sw} = 6'($urandom);
         prev = m_a;
         if (reset) begin
            m_a = 0; m_gen = 0; m_chg = 0; m_pop = 0;
         end else begin
            m_pop = 4'($countones(prev));
            if (scan) begin
               m_a = scan_val; m_gen = 0; m_chg = 0;
            end else if (shift_en) m_a = {m_a[6:0], shift_in};
            else if (write_enb) m_a[row] = val;
            else if (enable) begin
               nx = ref_step(m_a, w_col, e_col, wrap, {nw, n, ne}, {sw, s, se});
               m_chg = (nx != m_a);
               m_a = nx;
               m_gen = m_gen + 16'd1;
            end
         end
         tick();
         chk($sformatf("rnd%0d_alive", it), 32'(alive_col), 32'(m_a));
         chk($sformatf("rnd%0d_gen", it), 32'(gen_count), 32'(m_gen));
         chk($sformatf("rnd%0d_changed", it), 32'(changed), 32'(m_chg));
         chk($sformatf("rnd%0d_pop", it), 32'(pop_count), 32'(m_pop));
         chk($sformatf("rnd%0d_shift_out", it), 32'(shift_out), 32'(m_a[7]));
      end
      $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
      $finish;
   end
endmodule
